// File: rtl/kyber_pkg.sv
// Kyber arithmetic constants, coefficient and side-band types, and the Barrett reduction
// used by the NTT butterfly.
package kyber_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int KYBER_QINV = -3327;
    localparam int BARRETT_V  = 20159;
    localparam int MONT_R     = 2285;

    typedef logic signed [15:0] coeff_t;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } bfly_mode_e;

    // Data that bypasses the multiplier and is re-aligned with its product.
    typedef struct packed {
        bfly_mode_e  mode;
        logic [7:0]  tag;
        coeff_t      pass;
    } side_t;

    // Maps any 17-bit signed value to a congruent value with |r| <= Q.
    function automatic coeff_t barrett_reduce(input logic signed [16:0] x);
        logic signed [31:0] xe;
        logic signed [31:0] qt;
        logic signed [31:0] r;
        xe = 32'(x);
        qt = (BARRETT_V * xe + (32'sd1 <<< 25)) >>> 26;
        r  = xe - KYBER_Q * qt;
        return r[15:0];
    endfunction

endpackage

// File: rtl/mont_mul_pipe.sv
// Three-stage Montgomery multiplier m = zeta*mop*2^-16 mod Q, one issue per cycle,
// with a side-band lane delayed by the same three stages. All stages gated by en.
module mont_mul_pipe
    import kyber_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  coeff_t zeta,
    input  coeff_t mop,
    input  side_t  side_in,
    output coeff_t m,
    output side_t  side_out
);

    logic signed [31:0] p2, p3, tprod, red;
    coeff_t             t3;
    side_t              s2, s3;

    always_comb begin
        tprod = 32'(signed'(p2[15:0])) * KYBER_QINV;
        red   = p3 - 32'(t3) * KYBER_Q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2       <= '0;
            p3       <= '0;
            t3       <= '0;
            m        <= '0;
            s2       <= '0;
            s3       <= '0;
            side_out <= '0;
        end else if (en) begin
            p2       <= 32'(zeta) * 32'(mop);
            s2       <= side_in;
            t3       <= tprod[15:0];
            p3       <= p2;
            s3       <= s2;
            // red is an exact multiple of 2^16, so the upper half is the quotient
            m        <= red[31:16];
            side_out <= s3;
        end
    end

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined Kyber radix-2 CT/GS butterfly, 5-cycle latency with a global stall.
// Build option NTT_BFLY_CT_REDUCE_EN: Barrett-reduce the CT sum/difference instead of int16 wrap.
module ntt_butterfly
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [15:0] in_a_lo,
    input  logic [15:0] in_a_hi,
    input  logic [15:0] in_zeta,
    input  logic [7:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_lo,
    output logic [15:0] out_hi,
    output logic [7:0]  out_tag
);

    localparam int STAGES = 5;

    logic [STAGES:1]    vld_pipe;
    logic               adv;
    coeff_t             a_lo, a_hi;
    logic signed [16:0] s1_sum;
    side_t              s1_side_d, s1_side, mm_side;
    coeff_t             s1_mop_d, s1_mop, s1_zeta, mm_m;
    coeff_t             lo_d, hi_d;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign a_lo      = coeff_t'(in_a_lo);
    assign a_hi      = coeff_t'(in_a_hi);

    always_comb begin
        s1_sum         = 17'(a_lo) + 17'(a_hi);
        s1_side_d.mode = bfly_mode_e'(in_mode);
        s1_side_d.tag  = in_tag;
        s1_side_d.pass = a_lo;
        s1_mop_d       = a_hi;
        if (bfly_mode_e'(in_mode) == MODE_GS) begin
            s1_side_d.pass = barrett_reduce(s1_sum);
            s1_mop_d       = a_hi - a_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_side  <= '0;
            s1_mop   <= '0;
            s1_zeta  <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_side  <= s1_side_d;
            s1_mop   <= s1_mop_d;
            s1_zeta  <= coeff_t'(in_zeta);
        end
    end

    mont_mul_pipe u_mont (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (adv),
        .zeta     (s1_zeta),
        .mop      (s1_mop),
        .side_in  (s1_side),
        .m        (mm_m),
        .side_out (mm_side)
    );

    always_comb begin
`ifdef NTT_BFLY_CT_REDUCE_EN
        lo_d = barrett_reduce(17'(mm_side.pass) + 17'(mm_m));
        hi_d = barrett_reduce(17'(mm_side.pass) - 17'(mm_m));
`else
        lo_d = mm_side.pass + mm_m;
        hi_d = mm_side.pass - mm_m;
`endif
        if (mm_side.mode == MODE_GS) begin
            lo_d = mm_side.pass;
            hi_d = mm_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo  <= '0;
            out_hi  <= '0;
            out_tag <= '0;
        end else if (adv) begin
            out_lo  <= lo_d;
            out_hi  <= hi_d;
            out_tag <= mm_side.tag;
        end
    end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: vector table, stall stream, reset flush and
// random beats against a reference fqmul/barrett model, all checked through a scoreboard.
module tb_ntt_butterfly;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic        in_mode = 0;
    logic [15:0] in_a_lo = 0, in_a_hi = 0, in_zeta = 0;
    logic [7:0]  in_tag = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [15:0] out_lo, out_hi;
    logic [7:0]  out_tag;

    int checks = 0;
    int failures = 0;
    int out_count = 0;

    typedef struct {
        logic signed [15:0] lo;
        logic signed [15:0] hi;
        logic [7:0]         tag;
    } exp_t;

    typedef struct {
        logic               mode;
        logic signed [15:0] a_lo;
        logic signed [15:0] a_hi;
        logic signed [15:0] zeta;
        logic [7:0]         tag;
        logic signed [15:0] exp_lo;
        logic signed [15:0] exp_hi;
    } vec_t;

    exp_t sb[$];

    ntt_butterfly dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a_lo(in_a_lo), .in_a_hi(in_a_hi), .in_zeta(in_zeta), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_hi(out_hi), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference arithmetic written the way the Kyber C code does it.
    function automatic int sx16(input int v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    function automatic int m_barrett(input int x);
        int q;
        q = (20159 * x + (1 << 25)) >>> 26;
        return x - 3329 * q;
    endfunction

    function automatic int m_fqmul(input int z, input int b);
        int a, t;
        a = z * b;
        t = sx16(a * (-3327));
        return (a - t * 3329) >>> 16;
    endfunction

    function automatic exp_t model(input logic mode, input int lo, input int hi, input int z,
                                   input logic [7:0] tag);
        exp_t e;
        int m, rl, rh;
        if (mode) begin
            rl = m_barrett(lo + hi);
            rh = m_fqmul(z, sx16(hi - lo));
        end else begin
            m = m_fqmul(z, hi);
`ifdef NTT_BFLY_CT_REDUCE_EN
            rl = m_barrett(lo + m);
            rh = m_barrett(lo - m);
`else
            rl = sx16(lo + m);
            rh = sx16(lo - m);
`endif
        end
        e.lo = 16'(rl);
        e.hi = 16'(rh);
        e.tag = tag;
        return e;
    endfunction

    task automatic send(input logic mode, input logic signed [15:0] lo, input logic signed [15:0] hi,
                        input logic signed [15:0] z, input logic [7:0] tag, input exp_t e);
        int guard;
        bit ok;
        guard = 0;
        ok = 1;
        @(negedge clk);
        in_valid = 1; in_mode = mode; in_a_lo = lo; in_a_hi = hi; in_zeta = z; in_tag = tag;
        #1;
        while (!in_ready) begin
            guard++;
            if (guard > 200) begin
                checks++; failures++;
                $display("FAIL send_timeout in_ready stuck at %0b, required 1", in_ready);
                ok = 0;
                break;
            end
            @(negedge clk); #1;
        end
        if (ok) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk); g++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
        end
    endtask

    // Output monitor: scoreboard compare, stall hold and in_ready during stall.
    logic        stalled_prev = 0;
    logic [40:0] prev_out = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled_prev) begin
                checks++;
                if ({out_valid, out_lo, out_hi, out_tag} !== prev_out) begin
                    failures++;
                    $display("FAIL stall_hold got %h required %h", {out_valid, out_lo, out_hi, out_tag}, prev_out);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready got %b required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                exp_t e;
                out_count++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_out lo=%0d hi=%0d tag=%h with nothing expected",
                             $signed(out_lo), $signed(out_hi), out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_lo !== e.lo || out_hi !== e.hi || out_tag !== e.tag) begin
                        failures++;
                        $display("FAIL result got lo=%0d hi=%0d tag=%h required lo=%0d hi=%0d tag=%h",
                                 $signed(out_lo), $signed(out_hi), out_tag, e.lo, e.hi, e.tag);
                    end
                end
            end
            stalled_prev = out_valid && !out_ready;
            prev_out = {out_valid, out_lo, out_hi, out_tag};
        end else begin
            stalled_prev = 0;
        end
    end

    vec_t vecs[8];
    bit rand_done;

    initial begin
        vecs[0] = '{0, 16'sd500, 16'sd100, 16'sd2285, 8'h11, 16'sd600, 16'sd400};
        vecs[1] = '{1, 16'sd500, 16'sd100, 16'sd2285, 8'h22, 16'sd600, -16'sd400};
`ifdef NTT_BFLY_CT_REDUCE_EN
        vecs[2] = '{0, 16'sd32700, 16'sd100, 16'sd2285, 8'h33, -16'sd490, -16'sd690};
        vecs[3] = '{0, -16'sd32768, 16'sd0, 16'sd1234, 8'h44, 16'sd522, 16'sd522};
`else
        vecs[2] = '{0, 16'sd32700, 16'sd100, 16'sd2285, 8'h33, -16'sd32736, 16'sd32600};
        vecs[3] = '{0, -16'sd32768, 16'sd0, 16'sd1234, 8'h44, -16'sd32768, -16'sd32768};
`endif
        vecs[4] = '{1, 16'sd7, 16'sd7, 16'sd2285, 8'h55, 16'sd14, 16'sd0};
        vecs[5] = '{1, -16'sd32768, -16'sd32768, -16'sd17, 8'h66, 16'sd1044, 16'sd0};
        vecs[6] = '{0, 16'sd0, 16'sd1, 16'sd2285, 8'h77, 16'sd1, -16'sd1};
        vecs[7] = '{0, -16'sd1234, 16'sd0, 16'sd2285, 8'hff, -16'sd1234, -16'sd1234};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        if (out_lo !== 16'd0)   begin failures++; $display("FAIL rst_out_lo got %h required 0", out_lo); end
        if (out_hi !== 16'd0)   begin failures++; $display("FAIL rst_out_hi got %h required 0", out_hi); end
        if (out_tag !== 8'd0)   begin failures++; $display("FAIL rst_out_tag got %h required 0", out_tag); end
        @(negedge clk); rst_n = 1; #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b required 1", in_ready); end

        // First-beat latency: 5 edges after acceptance
        begin
            exp_t e;
            e.lo = 16'sd600; e.hi = 16'sd400; e.tag = 8'h11;
            send(0, 16'sd500, 16'sd100, 16'sd2285, 8'h11, e);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early out_valid=%b after 4 edges required 0", out_valid); end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_5 out_valid=%b after 5 edges required 1", out_valid); end
            wait_drain("latency");
        end

        // Table vectors, back to back
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.lo = vecs[i].exp_lo; e.hi = vecs[i].exp_hi; e.tag = vecs[i].tag;
            send(vecs[i].mode, vecs[i].a_lo, vecs[i].a_hi, vecs[i].zeta, vecs[i].tag, e);
        end
        wait_drain("table");

        // 16 alternating beats with out_ready low on cycles 7-9
        fork
            for (int i = 0; i < 16; i++) begin
                logic signed [15:0] l, h, z;
                l = 16'($urandom); h = 16'($urandom); z = 16'($urandom_range(0, 6657) - 3328);
                send(i[0], l, h, z, 8'(8'h80 + i), model(i[0], int'(l), int'(h), int'(z), 8'(8'h80 + i)));
            end
            begin
                repeat (7) @(posedge clk);
                #2 out_ready = 0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1;
            end
        join
        wait_drain("stall");

        // Reset with 4 beats in flight
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e = model(0, 100 * i, 7, 2285, 8'(i));
            send(0, 16'(100 * i), 16'sd7, 16'sd2285, 8'(i), e);
        end
        #2 rst_n = 0;
        #1;
        sb.delete();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_rst out_valid=%b required 0", out_valid); end
        if ({out_lo, out_hi, out_tag} !== 40'd0) begin failures++; $display("FAIL inflight_rst data=%h required 0", {out_lo, out_hi, out_tag}); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        begin
            int seen;
            seen = out_count;
            repeat (12) @(negedge clk);
            #1;
            checks++;
            if (out_count != seen) begin failures++; $display("FAIL stale_after_rst outputs=%0d required 0", out_count - seen); end
        end

        // Random beats against the model with random backpressure
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic signed [15:0] l, h, z;
                    logic m;
                    logic [7:0] t;
                    m = 1'($urandom); l = 16'($urandom); h = 16'($urandom); t = 8'($urandom);
                    z = 16'($urandom_range(0, 6657) - 3328);
                    if ($urandom_range(0, 7) == 0) @(negedge clk);
                    send(m, l, h, z, t, model(m, int'(l), int'(h), int'(z), t));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join
        wait_drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
